// File: rtl/tb4004_pkg.sv
// Shared constants and types for the TB4004 core's return-address stack.
package tb4004_pkg;

    localparam int PC_W        = 12;
    localparam int STACK_DEPTH = 8;

    // Full-stack behaviour on push.
    localparam bit STACK_SAT  = 1'b0;  // refuse the push
    localparam bit STACK_WRAP = 1'b1;  // overwrite the oldest entry

    // The single operation a cycle carries out, after priority resolution.
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_FLUSH,
        OP_XCHG,
        OP_PUSH,
        OP_POP
    } stack_op_e;

    // Resolve concurrent requests: flush > push&pop > push > pop.
    function automatic stack_op_e decode_op(input logic flush, input logic push, input logic pop);
        if (flush)            return OP_FLUSH;
        else if (push && pop) return OP_XCHG;
        else if (push)        return OP_PUSH;
        else if (pop)         return OP_POP;
        else                  return OP_IDLE;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Return-stack storage: DEPTH x ADDR_W, one synchronous write port and one
// asynchronous read port, every entry cleared by reset.
module stack_regfile
    import tb4004_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int SP_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              we,
    input  logic [SP_W-1:0]   waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [SP_W-1:0]   raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem_q [DEPTH];

    // Write one entry per cycle; clear the whole array on reset.
    // NOTE: the entries are reset on purpose so the top of stack reads 0 after reset;
    // a plain RAM would leave them unreset and free of the per-flop reset cost.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_return_stack.sv
// Subroutine return-address stack for the TB4004 core. JMS pushes, BBL pops;
// the top entry drives pcOut combinationally for the PC reload.
module pc_return_stack
    import tb4004_pkg::*;
#(
    parameter int ADDR_W    = PC_W,
    parameter int DEPTH     = STACK_DEPTH,
    parameter bit WRAP_MODE = STACK_SAT,
    localparam int SP_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clrErr,
    input  logic [ADDR_W-1:0] pcIn,
    output logic [ADDR_W-1:0] pcOut,
    output logic [SP_W-1:0]   sp,
    output logic [SP_W:0]     level,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              stackPcLoad
);

    localparam logic [SP_W:0]   LEVEL_FULL = (SP_W + 1)'(DEPTH);
    localparam logic [SP_W:0]   LEVEL_ONE  = (SP_W + 1)'(1);
    localparam logic [SP_W-1:0] SP_ONE     = SP_W'(1);

    logic [SP_W-1:0]   sp_q, sp_d;
    logic [SP_W:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              pcl_q, pcl_d;
    logic              we;
    logic [SP_W-1:0]   waddr;
    stack_op_e         op;

    stack_regfile #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SP_W   (SP_W)
    ) u_regfile (
        .clk   (clk),
        .rstN  (rstN),
        .we    (we),
        .waddr (waddr),
        .wdata (pcIn),
        .raddr (sp_q),
        .rdata (pcOut)
    );

    assign empty = (level_q == '0);
    assign full  = (level_q == LEVEL_FULL);

    // Resolve this cycle's operation and compute next pointer, level, flags and write.
    // NOTE: every signal gets its default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        op      = decode_op(flush, push, pop);
        sp_d    = sp_q;
        level_d = level_q;
        ovf_d   = ovf_q & ~clrErr;
        udf_d   = udf_q & ~clrErr;
        pcl_d   = 1'b0;
        we      = 1'b0;
        waddr   = sp_q + SP_ONE;

        unique case (op)
            OP_FLUSH: begin
                sp_d    = '0;
                level_d = '0;
            end
            OP_XCHG: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    // Replace the top in place; the old top is still on pcOut this cycle.
                    we    = 1'b1;
                    waddr = sp_q;
                    pcl_d = 1'b1;
                end
            end
            OP_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    sp_d    = sp_q + SP_ONE;
                    level_d = level_q + LEVEL_ONE;
                end else begin
                    ovf_d = 1'b1;
                    if (WRAP_MODE) begin
                        // Circular: overwrite the oldest entry, level stays at DEPTH.
                        we   = 1'b1;
                        sp_d = sp_q + SP_ONE;
                    end
                end
            end
            OP_POP: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    sp_d    = sp_q - SP_ONE;
                    level_d = level_q - LEVEL_ONE;
                    pcl_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control state register; reset clears everything and drops any pending reload pulse.
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sp_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            pcl_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            pcl_q   <= pcl_d;
        end
    end

    assign sp          = sp_q;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;
    assign stackPcLoad = pcl_q;

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench for pc_return_stack: one saturating and one wrapping instance
// share stimulus; expected pop data is queued and compared as the pops happen.
module tb_pc_return_stack;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rstN;
    logic          push, pop, flush, clrErr;
    logic [AW-1:0] pcIn;

    logic [AW-1:0] pc_out [2];
    logic [2:0]    sp_o   [2];
    logic [3:0]    lvl    [2];
    logic          emp    [2];
    logic          ful    [2];
    logic          ovf    [2];
    logic          udf    [2];
    logic          pcl    [2];

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] exp_q [2][$];

    always #5 clk = ~clk;

    pc_return_stack #(.ADDR_W(AW), .DEPTH(8), .WRAP_MODE(1'b0)) dut_sat (
        .clk(clk), .rstN(rstN), .push(push), .pop(pop), .flush(flush), .clrErr(clrErr),
        .pcIn(pcIn), .pcOut(pc_out[0]), .sp(sp_o[0]), .level(lvl[0]), .empty(emp[0]),
        .full(ful[0]), .overflow(ovf[0]), .underflow(udf[0]), .stackPcLoad(pcl[0])
    );

    pc_return_stack #(.ADDR_W(AW), .DEPTH(8), .WRAP_MODE(1'b1)) dut_wrap (
        .clk(clk), .rstN(rstN), .push(push), .pop(pop), .flush(flush), .clrErr(clrErr),
        .pcIn(pcIn), .pcOut(pc_out[1]), .sp(sp_o[1]), .level(lvl[1]), .empty(emp[1]),
        .full(ful[1]), .overflow(ovf[1]), .underflow(udf[1]), .stackPcLoad(pcl[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input int d, input string tag, input int e_sp, input int e_lvl,
                               input int e_ovf, input int e_udf, input int e_pcl, input int e_pc);
        string t;
        t = $sformatf("%s[dut%0d]", tag, d);
        check({t, ".sp"},          32'(sp_o[d]),   32'(e_sp));
        check({t, ".level"},       32'(lvl[d]),    32'(e_lvl));
        check({t, ".overflow"},    32'(ovf[d]),    32'(e_ovf));
        check({t, ".underflow"},   32'(udf[d]),    32'(e_udf));
        check({t, ".stackPcLoad"}, 32'(pcl[d]),    32'(e_pcl));
        check({t, ".pcOut"},       32'(pc_out[d]), 32'(e_pc));
        check({t, ".empty"},       32'(emp[d]),    32'(e_lvl == 0));
        check({t, ".full"},        32'(ful[d]),    32'(e_lvl == 8));
    endtask

    task automatic drive(input logic pu, input logic po, input logic fl, input logic ce,
                         input logic [AW-1:0] d);
        push = pu; pop = po; flush = fl; clrErr = ce; pcIn = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] e;

        // ---- Reset ----
        rstN = 1'b0;
        idle();
        #12;
        for (int d = 0; d < 2; d++) check_state(d, "reset", 0, 0, 0, 0, 0, 0);
        rstN = 1'b1;
        cyc();

        // ---- 1: push two, pop one ----
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h123); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h456); cyc();
        idle();
        for (int d = 0; d < 2; d++) check_state(d, "t1_push2", 2, 2, 0, 0, 0, 12'h456);
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        #1;
        for (int d = 0; d < 2; d++) check($sformatf("t1_pop_cycle_pc[dut%0d]", d), 32'(pc_out[d]), 32'h456);
        cyc();
        idle();
        for (int d = 0; d < 2; d++) check_state(d, "t1_after_pop", 1, 1, 0, 0, 1, 12'h123);
        cyc();
        for (int d = 0; d < 2; d++) check($sformatf("t1_pulse_end[dut%0d]", d), 32'(pcl[d]), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0); cyc();
        idle();
        for (int d = 0; d < 2; d++) check_state(d, "t1_flush", 0, 0, 0, 0, 0, 0);

        // ---- 2/3: nine pushes into an 8-deep stack ----
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, AW'(i));
            cyc();
        end
        idle();
        check_state(0, "t2_full", 0, 8, 1, 0, 0, 12'h008);
        check_state(1, "t3_full", 1, 8, 1, 0, 0, 12'h009);
        for (int v = 8; v >= 1; v--) exp_q[0].push_back(AW'(v));
        for (int v = 9; v >= 2; v--) exp_q[1].push_back(AW'(v));
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
            #1;
            for (int d = 0; d < 2; d++) begin
                e = exp_q[d].pop_front();
                check($sformatf("t23_pop%0d_pc[dut%0d]", i, d), 32'(pc_out[d]), 32'(e));
            end
            cyc();
        end
        idle();
        check_state(0, "t2_drained", 0, 0, 1, 0, 1, 12'h008);
        check_state(1, "t3_drained", 1, 0, 1, 0, 1, 12'h009);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0); cyc();
        idle();
        check_state(0, "t2_clr", 0, 0, 0, 0, 0, 12'h008);
        check_state(1, "t3_clr", 1, 0, 0, 0, 0, 12'h009);

        // ---- 4: underflow and clrErr ----
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0); cyc();
        idle();
        check_state(0, "t4_udf", 0, 0, 0, 1, 0, 12'h008);
        check_state(1, "t4_udf", 1, 0, 0, 1, 0, 12'h009);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0); cyc();
        for (int d = 0; d < 2; d++) check($sformatf("t4_clr[dut%0d]", d), 32'(udf[d]), 32'h0);
        cyc();
        for (int d = 0; d < 2; d++) check($sformatf("t4_clr_noerr[dut%0d]", d), 32'(udf[d]), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0); cyc();
        idle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("t4_set_beats_clr[dut%0d]", d), 32'(udf[d]), 32'h1);
            check($sformatf("t4_no_pulse[dut%0d]", d), 32'(pcl[d]), 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0); cyc();

        // ---- 5: exchange (underflow left set to watch flush keep it) ----
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0); cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h011); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h022); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h0AA); cyc();
        idle();
        for (int d = 0; d < 2; d++) check_state(d, "t5_setup", 3, 3, 0, 1, 0, 12'h0AA);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h0BB);
        #1;
        for (int d = 0; d < 2; d++) check($sformatf("t5_xchg_cycle_pc[dut%0d]", d), 32'(pc_out[d]), 32'h0AA);
        cyc();
        idle();
        for (int d = 0; d < 2; d++) check_state(d, "t5_after_xchg", 3, 3, 0, 1, 1, 12'h0BB);
        cyc();
        for (int d = 0; d < 2; d++) check($sformatf("t5_pulse_end[dut%0d]", d), 32'(pcl[d]), 32'h0);

        // ---- 6: flush beats push; flags untouched ----
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h0CC); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h0DD); cyc();
        idle();
        for (int d = 0; d < 2; d++) check_state(d, "t6_level5", 5, 5, 0, 1, 0, 12'h0DD);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 12'h0EE); cyc();
        idle();
        for (int d = 0; d < 2; d++) check_state(d, "t6_flush_push", 0, 0, 0, 1, 0, 12'h008);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0); cyc();

        // ---- 6b: asynchronous reset in the middle of a pop ----
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h0AB); cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        #2;
        rstN = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check_state(d, "t6_async_rst", 0, 0, 0, 0, 0, 0);
        cyc();
        for (int d = 0; d < 2; d++) check($sformatf("t6_rst_no_pulse[dut%0d]", d), 32'(pcl[d]), 32'h0);
        idle();
        rstN = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
